clock_switch_ctrl: RTL and testbench
====================================

CLOCK_SWITCH_CTRL -- requirements
Module: clock_switch_ctrl

Interface
REQ-001 SHALL have parameter MIN_TOGGLES, default 4: synchronized target-toggle edges needed to declare the target clock alive (>=1).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 64: maximum CHECK duration in clk cycles (>MIN_TOGGLES).
REQ-003 SHALL have parameter SETTLE_CYCLES, default 16: clk cycles the block waits after changing sel before reporting done (>=1).
REQ-004 clk  input  1  single control clock; all state updates on its rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 req_valid  input  1  switch request valid.
REQ-007 req_sel  input  1  requested source: 1 = clk1, 0 = clk0.
REQ-008 tog0  input  1  asynchronous divide-by-2 toggle from the clk0 domain.
REQ-009 tog1  input  1  asynchronous divide-by-2 toggle from the clk1 domain.
REQ-010 req_ready  output  1  block can accept a request.
REQ-011 sel  output  1  registered select driving the glitch-free clock mux.
REQ-012 busy  output  1  a request is in progress.
REQ-013 done  output  1  one-cycle pulse: request completed successfully.
REQ-014 err  output  1  one-cycle pulse: target clock dead, request aborted.

Function
REQ-015 SHALL implement the FSM states IDLE, CHECK, SETTLE, DONE and ERR.
REQ-016 req_ready SHALL equal (state==IDLE); busy SHALL equal (state!=IDLE).
REQ-017 Acceptance SHALL occur on a rising edge with req_valid&&req_ready; req_sel is captured as the target at that edge.
REQ-018 A request with req_valid high while busy SHALL be ignored: not queued and not stored.
REQ-019 An accepted target equal to the current sel SHALL go IDLE->DONE, pulsing done in the cycle after acceptance, with no CHECK and sel unchanged.
REQ-020 An accepted target different from sel SHALL go IDLE->CHECK and clear the edge counter and the window counter.
REQ-021 tog0 and tog1 SHALL each pass a 2-flop synchronizer plus an edge-detect flop; each rising or falling synchronized edge SHALL count as one toggle.
REQ-022 In CHECK, only target-source edges SHALL increment the edge counter, and the window counter SHALL increment every cycle.
REQ-023 When the edge count reaches MIN_TOGGLES, the FSM SHALL go to SETTLE and sel SHALL take the target value on that same edge.
REQ-024 When the window count reaches TIMEOUT_CYCLES without MIN_TOGGLES edges, the FSM SHALL go to ERR; err SHALL pulse for one cycle, sel SHALL be unchanged, and the FSM SHALL return to IDLE.
REQ-025 If the MIN_TOGGLES-th edge and the timeout occur in the same cycle, success SHALL take priority.
REQ-026 SETTLE SHALL last exactly SETTLE_CYCLES cycles, then go to DONE; done SHALL be high exactly SETTLE_CYCLES cycles after the first cycle sel shows its new value.
REQ-027 DONE and ERR SHALL each last one cycle and then return to IDLE; done and err SHALL never be high together.
REQ-028 Counter widths SHALL be clog2(parameter+1) bits, and counters SHALL saturate rather than wrap.
REQ-029 sel SHALL change only on the CHECK->SETTLE transition or on reset.

Reset
REQ-030 While rst_n is low: state=IDLE, sel=0, done=0, err=0, busy=0, all counters and synchronizer flops =0; req_valid SHALL be ignored.
REQ-031 Reset assertion mid-operation SHALL abort immediately and asynchronously: sel SHALL return to 0 with no done or err pulse.
REQ-032 The first request SHALL be accepted on the first rising edge after rst_n deasserts.

Structure
REQ-033 The FSM state encoding and the default parameter values SHALL live in the shared package clk_sw_pkg.
REQ-034 Synchronizer plus edge detect SHALL be the sub-module sync_edge_det, instantiated twice (tog0, tog1).

Verification
REQ-035 The bench SHALL cover: reset, then req_sel=1 with tog1 toggling every 3 clk -> 4 edges counted, sel rises, done exactly 16 cycles later, err=0.
REQ-036 The bench SHALL cover: req_sel=1 with tog1 static -> err pulse in the cycle after the 64th CHECK cycle, sel stays 0, done=0.
REQ-037 The bench SHALL cover: sel=0, req_sel=0 accepted at T -> done at T+1, busy high for exactly 1 cycle, sel unchanged.
REQ-038 The bench SHALL cover: req_valid pulsed with req_sel=0 during SETTLE of a 0->1 switch -> ignored, sel ends at 1, exactly one done.
REQ-039 The bench SHALL cover: rst_n dropped 5 cycles into SETTLE -> sel=0 and busy=0 asynchronously, no done; after release, a new request succeeds.
REQ-040 The bench SHALL cover: 4th edge arriving in window cycle 64 -> SETTLE entered, done asserted, no err.

Source files
------------

// File: rtl/clk_sw_pkg.sv
// rtl/clk_sw_pkg.sv - shared FSM encoding and default parameters for the clock switch controller
package clk_sw_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CHECK  = 3'd1,
        ST_SETTLE = 3'd2,
        ST_DONE   = 3'd3,
        ST_ERR    = 3'd4
    } state_e;

    localparam int DEF_MIN_TOGGLES    = 4;
    localparam int DEF_TIMEOUT_CYCLES = 64;
    localparam int DEF_SETTLE_CYCLES  = 16;

endpackage

// File: rtl/sync_edge_det.sv
// rtl/sync_edge_det.sv - two-flop synchronizer with any-edge detect on an asynchronous toggle
module sync_edge_det (
    input  logic clk,
    input  logic rst_n,
    input  logic async_i,
    output logic edge_o
);

    logic meta_q;
    logic sync_q;
    logic prev_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            prev_q <= 1'b0;
        end else begin
            meta_q <= async_i;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    // A divide-by-2 toggle carries one source edge per level change, rising or falling.
    assign edge_o = sync_q ^ prev_q;

endmodule

// File: rtl/clock_switch_ctrl.sv
// rtl/clock_switch_ctrl.sv - verifies the target clock is alive, then flips the glitch-free mux select
module clock_switch_ctrl
    import clk_sw_pkg::*;
#(
    parameter int MIN_TOGGLES    = DEF_MIN_TOGGLES,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
    parameter int SETTLE_CYCLES  = DEF_SETTLE_CYCLES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic req_valid,
    input  logic req_sel,
    input  logic tog0,
    input  logic tog1,
    output logic req_ready,
    output logic sel,
    output logic busy,
    output logic done,
    output logic err
);

    localparam int EW = $clog2(MIN_TOGGLES + 1);
    localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int SW = $clog2(SETTLE_CYCLES + 1);

    localparam logic [EW-1:0] EDGE_MAX   = EW'(MIN_TOGGLES);
    localparam logic [WW-1:0] WIN_MAX    = WW'(TIMEOUT_CYCLES);
    localparam logic [SW-1:0] SETTLE_MAX = SW'(SETTLE_CYCLES);

    state_e        state_q,      state_d;
    logic          sel_q,        sel_d;
    logic          target_q,     target_d;
    logic [EW-1:0] edge_cnt_q,   edge_cnt_d;
    logic [WW-1:0] win_cnt_q,    win_cnt_d;
    logic [SW-1:0] settle_cnt_q, settle_cnt_d;

    logic          edge0;
    logic          edge1;
    logic          tgt_edge;
    logic [EW-1:0] edge_inc;
    logic [WW-1:0] win_inc;
    logic [SW-1:0] settle_inc;

    sync_edge_det u_sync0 (
        .clk     (clk),
        .rst_n   (rst_n),
        .async_i (tog0),
        .edge_o  (edge0)
    );

    sync_edge_det u_sync1 (
        .clk     (clk),
        .rst_n   (rst_n),
        .async_i (tog1),
        .edge_o  (edge1)
    );

    // Saturating increments: a counter that already hit its limit holds there.
    always_comb begin
        edge_inc   = (edge_cnt_q   >= EDGE_MAX)   ? edge_cnt_q   : edge_cnt_q   + EW'(1);
        win_inc    = (win_cnt_q    >= WIN_MAX)    ? win_cnt_q    : win_cnt_q    + WW'(1);
        settle_inc = (settle_cnt_q >= SETTLE_MAX) ? settle_cnt_q : settle_cnt_q + SW'(1);
        tgt_edge   = target_q ? edge1 : edge0;
    end

    always_comb begin
        state_d      = state_q;
        sel_d        = sel_q;
        target_d     = target_q;
        edge_cnt_d   = edge_cnt_q;
        win_cnt_d    = win_cnt_q;
        settle_cnt_d = settle_cnt_q;

        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    target_d = req_sel;
                    if (req_sel == sel_q) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d    = ST_CHECK;
                        edge_cnt_d = '0;
                        win_cnt_d  = '0;
                    end
                end
            end
            ST_CHECK: begin
                if (tgt_edge) begin
                    edge_cnt_d = edge_inc;
                end
                win_cnt_d = win_inc;
                // Enough edges wins even if the window closes on the same cycle.
                if (edge_cnt_d == EDGE_MAX) begin
                    state_d      = ST_SETTLE;
                    sel_d        = target_q;
                    settle_cnt_d = '0;
                end else if (win_cnt_d == WIN_MAX) begin
                    state_d = ST_ERR;
                end
            end
            ST_SETTLE: begin
                settle_cnt_d = settle_inc;
                if (settle_cnt_d == SETTLE_MAX) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            ST_ERR:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            sel_q        <= 1'b0;
            target_q     <= 1'b0;
            edge_cnt_q   <= '0;
            win_cnt_q    <= '0;
            settle_cnt_q <= '0;
        end else begin
            state_q      <= state_d;
            sel_q        <= sel_d;
            target_q     <= target_d;
            edge_cnt_q   <= edge_cnt_d;
            win_cnt_q    <= win_cnt_d;
            settle_cnt_q <= settle_cnt_d;
        end
    end

    assign req_ready = (state_q == ST_IDLE);
    assign busy      = (state_q != ST_IDLE);
    assign done      = (state_q == ST_DONE);
    assign err       = (state_q == ST_ERR);
    assign sel       = sel_q;

endmodule

// File: tb/tb_clock_switch_ctrl.sv
// tb/tb_clock_switch_ctrl.sv - scoreboard bench for clock_switch_ctrl with directed switch scenarios
module tb_clock_switch_ctrl;

    logic clk = 1'b0;
    logic rst_n;
    logic req_valid;
    logic req_sel;
    logic tog0;
    logic tog1;
    logic req_ready;
    logic sel;
    logic busy;
    logic done;
    logic err;

    int n_checks  = 0;
    int n_err     = 0;
    int cyc       = 0;
    int model_sel = 0;

    typedef struct {
        bit is_done;
        int cyc;
        int sel;
        int chg;
        int len;
    } exp_t;

    exp_t sb[$];

    logic mon_busy_prev  = 1'b0;
    logic mon_sel_prev   = 1'b0;
    int   mon_busy_start = 0;
    int   mon_sel_chg    = 0;

    clock_switch_ctrl #(
        .MIN_TOGGLES    (4),
        .TIMEOUT_CYCLES (64),
        .SETTLE_CYCLES  (16)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_sel   (req_sel),
        .tog0      (tog0),
        .tog1      (tog1),
        .req_ready (req_ready),
        .sel       (sel),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (busy === 1'b1 && mon_busy_prev !== 1'b1) mon_busy_start = cyc;
            if (sel !== mon_sel_prev) mon_sel_chg = cyc;
            if (done === 1'b1 || err === 1'b1) begin
                chk("done_err_exclusive", 32'(done & err), 0);
                if (sb.size() == 0) begin
                    chk("unexpected_pulse", {30'd0, done, err}, 0);
                end else begin
                    e = sb.pop_front();
                    chk("pulse_is_done", 32'(done), 32'(e.is_done));
                    chk("pulse_cycle", cyc, e.cyc);
                    chk("sel_at_pulse", 32'(sel), e.sel);
                    chk("busy_length", cyc - mon_busy_start + 1, e.len);
                    if (e.chg >= 0) chk("sel_change_cycle", mon_sel_chg, e.chg);
                end
            end
            mon_busy_prev = busy;
            mon_sel_prev  = sel;
        end
    end

    // Toggle at loop index i flips just after edge a-1+i and is counted at edge a+i+2,
    // i.e. in CHECK window cycle i+2 (two sync flops plus the edge-detect flop).
    task automatic run_case(input string name, input int tgt, input int which,
                            input int t0, input int t1, input int t2, input int t3,
                            input int spur_i, input int rst_at);
        int   a;
        int   ncyc;
        int   w4;
        int   tg[4];
        exp_t e;
        tg[0] = t0; tg[1] = t1; tg[2] = t2; tg[3] = t3;
        a = cyc + 1;
        if (tgt == model_sel) begin
            e.is_done = 1'b1; e.cyc = a; e.chg = -1; e.len = 1;
        end else if (which == tgt && t3 >= 0 && t3 + 2 <= 64) begin
            w4 = t3 + 2;
            e.is_done = 1'b1; e.cyc = a + w4 + 16; e.chg = a + w4; e.len = w4 + 17;
            model_sel = tgt;
        end else begin
            e.is_done = 1'b0; e.cyc = a + 64; e.chg = -1; e.len = 65;
        end
        e.sel = model_sel;
        if (rst_at >= 0) begin
            ncyc = 30;
            model_sel = 0;
        end else begin
            ncyc = e.cyc - a + 3;
            sb.push_back(e);
        end

        req_valid = 1'b1;
        req_sel   = (tgt != 0);
        for (int i = 0; i < ncyc; i++) begin
            if (i == spur_i) begin
                req_valid = 1'b1;
                req_sel   = (tgt == 0);
                chk({name, "_ready_while_busy"}, 32'(req_ready), 0);
            end
            for (int j = 0; j < 4; j++) begin
                if (tg[j] == i) begin
                    if (which != 0) tog1 = ~tog1;
                    else            tog0 = ~tog0;
                end
            end
            if (rst_at < 0 && i == e.cyc - a + 2) begin
                chk({name, "_busy_after"}, 32'(busy), 0);
                chk({name, "_ready_after"}, 32'(req_ready), 1);
            end
            if (i == rst_at) begin
                #3;
                rst_n = 1'b0;
                #1;
                chk({name, "_async_sel"}, 32'(sel), 0);
                chk({name, "_async_busy"}, 32'(busy), 0);
                chk({name, "_async_done"}, 32'(done), 0);
            end
            @(posedge clk);
            #1;
            req_valid = 1'b0;
        end

        if (rst_at < 0) chk({name, "_sel_end"}, 32'(sel), model_sel);
        else            chk({name, "_busy_in_reset"}, 32'(busy), 0);
        chk({name, "_scoreboard_drained"}, sb.size(), 0);
        sb.delete();
    endtask

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: time limit reached before summary, limit %0d", 100000);
        $fatal(1);
    end

    initial begin : stimulus
        rst_n     = 1'b0;
        req_valid = 1'b1;
        req_sel   = 1'b1;
        tog0      = 1'b0;
        tog1      = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_sel", 32'(sel), 0);
        chk("reset_busy", 32'(busy), 0);
        chk("reset_ready", 32'(req_ready), 1);
        chk("reset_done", 32'(done), 0);
        chk("reset_err", 32'(err), 0);
        rst_n     = 1'b1;
        req_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("idle_after_release", 32'(busy), 0);

        run_case("timeout_nontarget_edges", 1, 0, 0, 3, 6, 9, -1, -1);
        run_case("same_sel0", 0, 0, -1, -1, -1, -1, -1, -1);
        run_case("switch_to1", 1, 1, 0, 3, 6, 9, -1, -1);
        run_case("switch_to0", 0, 0, 0, 2, 4, 6, -1, -1);
        run_case("ignore_in_settle", 1, 1, 0, 3, 6, 9, 15, -1);
        run_case("edge_at_win64", 0, 0, 0, 3, 6, 62, -1, -1);
        run_case("edge_at_win65", 1, 1, 0, 3, 6, 63, -1, -1);
        run_case("reset_in_settle", 1, 1, 0, 3, 6, 9, -1, 17);
        rst_n = 1'b1;
        run_case("first_after_reset", 1, 1, 0, 3, 6, 9, -1, -1);
        run_case("same_sel1", 1, 1, -1, -1, -1, -1, -1, -1);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
